dds_freq_meter: RTL and testbench



---
 rtl/dds_freq_meter_if.sv | 30 +++
 rtl/dds_freq_meter.sv | 126 ++++++++++++
 tb/tb_dds_freq_meter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_freq_meter_if.sv
// Sample stream, measurement control and result bundle of the DDS frequency meter.
// The master drives samples and control, and the slave (the meter) drives results and debug state.
interface dds_freq_meter_if #(
  parameter int DATA_WIDTH = 12,
  parameter int GATE_WIDTH = 24
);
  // Handshakes: din is consumed in every cycle with din_valid=1 and has no backpressure.
  // start is accepted in any cycle where busy=0 (IDLE). done pulses once when results update.
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  start;
  logic [GATE_WIDTH-1:0] gate_len;
  logic                  busy;
  logic                  done;
  logic [GATE_WIDTH-1:0] edge_cnt;
  logic [GATE_WIDTH-1:0] span;
  logic                  span_valid;
  logic                  dbg_run;
  logic [1:0]            dbg_det;

  modport master (
    output din_valid, din, start, gate_len,
    input  busy, done, edge_cnt, span, span_valid, dbg_run, dbg_det
  );

  modport slave (
    input  din_valid, din, start, gate_len,
    output busy, done, edge_cnt, span, span_valid, dbg_run, dbg_det
  );
endinterface

// File: rtl/dds_freq_meter.sv
// Frequency meter for an offset-binary DDS sample stream: counts hysteresis-filtered
// rising mid-scale crossings over a gate window and reports the first-to-last crossing span.
module dds_freq_meter #(
  parameter int DATA_WIDTH = 12,
  parameter int GATE_WIDTH = 24,
  parameter int HYST       = 64
) (
  input logic            clk,
  input logic            rst,
  dds_freq_meter_if.slave m
);
  localparam int MID = 1 << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] HI_TH = DATA_WIDTH'(MID + HYST);
  localparam logic [DATA_WIDTH-1:0] LO_TH = DATA_WIDTH'(MID - HYST);

  typedef enum logic [1:0] {
    DET_UNKNOWN = 2'd0,
    DET_LO      = 2'd1,
    DET_HI      = 2'd2
  } det_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;
  det_t   det, det_next;

  logic                  is_hi, is_lo, rise;
  logic                  accept, finish;
  logic [GATE_WIDTH-1:0] last_idx;
  logic [GATE_WIDTH-1:0] elapsed;
  logic [GATE_WIDTH-1:0] work_cnt;
  logic [GATE_WIDTH-1:0] first_ts, last_ts;
  logic [GATE_WIDTH-1:0] cnt_final, last_final, span_final;
  logic                  done_r, span_valid_r;
  logic [GATE_WIDTH-1:0] edge_cnt_r, span_r;

  assign is_hi = (m.din >= HI_TH);
  assign is_lo = (m.din < LO_TH);
  assign rise  = m.din_valid && is_hi && (det == DET_LO);

  // In-band samples hold the detector, so chatter around mid-scale yields one edge.
  always_comb begin
    det_next = det;
    if (m.din_valid) begin
      if (is_hi)      det_next = DET_HI;
      else if (is_lo) det_next = DET_LO;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (m.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (elapsed == last_idx) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise in the final window cycle still belongs to this window's result.
  assign cnt_final  = work_cnt + GATE_WIDTH'(rise);
  assign last_final = rise ? elapsed : last_ts;
  assign span_final = (cnt_final >= GATE_WIDTH'(2)) ? (last_final - first_ts) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      det          <= DET_UNKNOWN;
      last_idx     <= '0;
      elapsed      <= '0;
      work_cnt     <= '0;
      first_ts     <= '0;
      last_ts      <= '0;
      done_r       <= 1'b0;
      edge_cnt_r   <= '0;
      span_r       <= '0;
      span_valid_r <= 1'b0;
    end else begin
      state  <= state_next;
      det    <= det_next;
      done_r <= finish;
      if (accept) begin
        last_idx <= (m.gate_len == '0) ? '0 : (m.gate_len - GATE_WIDTH'(1));
        elapsed  <= '0;
        work_cnt <= '0;
        first_ts <= '0;
        last_ts  <= '0;
      end
      if (state == RUN) begin
        elapsed <= elapsed + GATE_WIDTH'(1);
        if (rise) begin
          work_cnt <= work_cnt + GATE_WIDTH'(1);
          if (work_cnt == '0) first_ts <= elapsed;
          last_ts <= elapsed;
        end
      end
      if (finish) begin
        edge_cnt_r   <= cnt_final;
        span_r       <= span_final;
        span_valid_r <= (cnt_final >= GATE_WIDTH'(2));
      end
    end
  end

  assign m.busy       = (state == RUN);
  assign m.done       = done_r;
  assign m.edge_cnt   = edge_cnt_r;
  assign m.span       = span_r;
  assign m.span_valid = span_valid_r;
  assign m.dbg_run    = (state == RUN);
  assign m.dbg_det    = det;
endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed and randomized checks of dds_freq_meter against a crossing-timestamp reference model.
module tb_dds_freq_meter;
  localparam int DATA_WIDTH = 12;
  localparam int GATE_WIDTH = 24;
  localparam int HYST       = 64;
  localparam int MID        = 1 << (DATA_WIDTH - 1);

  logic clk = 1'b0;
  logic rst;

  dds_freq_meter_if #(.DATA_WIDTH(DATA_WIDTH), .GATE_WIDTH(GATE_WIDTH)) m ();

  dds_freq_meter #(
    .DATA_WIDTH(DATA_WIDTH),
    .GATE_WIDTH(GATE_WIDTH),
    .HYST      (HYST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m  (m)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Classifies each valid sample, records the window offsets of LO->HI changes,
  // and derives the results from the first/last recorded offsets.
  int m_level   = 0;  // 0 unknown, 1 low, 2 high
  bit m_running = 0;
  int m_elapsed = 0;
  int m_limit   = 0;
  int m_cls;
  bit m_rise;
  int rise_q[$];
  int m_exp_cnt  = 0;
  int m_exp_span = 0;
  int m_exp_sv   = 0;

  always @(posedge clk) begin
    m_cls = 0;
    if (m.din_valid === 1'b1) begin
      if (int'(m.din) >= MID + HYST)     m_cls = 2;
      else if (int'(m.din) < MID - HYST) m_cls = 1;
    end
    m_rise = (m_cls == 2) && (m_level == 1);
    if (rst) begin
      m_level   = 0;
      m_running = 0;
    end else begin
      if (m_running) begin
        if (m_rise) rise_q.push_back(m_elapsed);
        if (m_elapsed == m_limit) begin
          m_running  = 0;
          m_exp_cnt  = rise_q.size();
          m_exp_span = (rise_q.size() >= 2) ? (rise_q[rise_q.size()-1] - rise_q[0]) : 0;
          m_exp_sv   = (rise_q.size() >= 2) ? 1 : 0;
        end else begin
          m_elapsed++;
        end
      end else if (m.start === 1'b1) begin
        m_running = 1;
        m_elapsed = 0;
        m_limit   = (m.gate_len == '0) ? 0 : int'(m.gate_len) - 1;
        rise_q.delete();
      end
      if (m_cls != 0) m_level = m_cls;
    end
  end

  // ---------------- stimulus generator ----------------
  int cyc       = 0;
  int base      = 0;
  int mode      = 5;
  int const_din = MID;

  function automatic int lo_val();
    return ($urandom_range(0, 3) == 0) ? (MID - HYST - 1) : int'($urandom_range(0, MID - HYST - 1));
  endfunction

  function automatic int hi_val();
    return ($urandom_range(0, 3) == 0) ? (MID + HYST) : int'($urandom_range(MID + HYST, 2 * MID - 1));
  endfunction

  task automatic drive_sample(input int i);
    int ph;
    int v;
    bit vld;
    vld = 1'b1;
    v   = const_din;
    case (mode)
      0, 3: begin
        ph = ((i % 100) + 100) % 100;
        v  = (ph < 50) ? lo_val() : hi_val();
        if (mode == 3 && (i % 2 != 0)) begin
          vld = 1'b0;
          v   = int'($urandom_range(0, 2 * MID - 1));
        end
      end
      1: v = (i % 2 != 0) ? (MID + 40) : (MID - 40);
      2: begin
        ph = ((i % 200) + 200) % 200;
        if (ph < 100)      v = 1000;
        else if (ph < 105) v = (ph % 2 != 0) ? 2100 : 2000;
        else               v = 3000;
      end
      4: begin
        vld = ($urandom_range(0, 3) != 0);
        v   = int'($urandom_range(0, 2 * MID - 1));
      end
      default: v = const_din;
    endcase
    m.din_valid = vld;
    m.din       = DATA_WIDTH'(v);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    drive_sample(cyc - base);
  endtask

  // Runs n cycles so that the sample presented at the last of them has pattern index idx.
  task automatic sync_to(input int n, input int idx);
    base = cyc + n - idx;
    repeat (n) next_cycle();
  endtask

  // Starts a window at the current cycle and checks timing and results.
  task automatic measure(input string tag, input int gate, input int mid_at,
                         input int exp_cnt, input int exp_span);
    int t;
    int busy_cycles;
    int geff;
    bit seen;
    geff        = (gate == 0) ? 1 : gate;
    m.start     = 1'b1;
    m.gate_len  = GATE_WIDTH'(gate);
    t           = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && t < geff + 20) begin
      next_cycle();
      t++;
      m.start = (t == mid_at);
      if (t == mid_at) m.gate_len = GATE_WIDTH'(5);
      if (m.busy === 1'b1) busy_cycles++;
      if (m.done === 1'b1) seen = 1'b1;
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/done_latency"}, 32'(t), 32'(geff + 1));
    check({tag, "/busy_cycles"}, 32'(busy_cycles), 32'(geff));
    check({tag, "/edge_cnt"}, 32'(m.edge_cnt), 32'(m_exp_cnt));
    check({tag, "/span"}, 32'(m.span), 32'(m_exp_span));
    check({tag, "/span_valid"}, 32'(m.span_valid), 32'(m_exp_sv));
    if (exp_cnt >= 0)  check({tag, "/edge_cnt_plan"}, 32'(m.edge_cnt), 32'(exp_cnt));
    if (exp_span >= 0) check({tag, "/span_plan"}, 32'(m.span), 32'(exp_span));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int any_done;
    rst         = 1'b1;
    m.start     = 1'b0;
    m.gate_len  = '0;
    m.din_valid = 1'b0;
    m.din       = DATA_WIDTH'(MID);
    mode        = 5;
    repeat (3) next_cycle();
    rst = 1'b0;
    check("reset/busy", 32'(m.busy), 32'd0);
    check("reset/done", 32'(m.done), 32'd0);
    check("reset/edge_cnt", 32'(m.edge_cnt), 32'd0);
    check("reset/span", 32'(m.span), 32'd0);
    check("reset/span_valid", 32'(m.span_valid), 32'd0);
    check("reset/fsm", 32'(m.dbg_run), 32'd0);
    check("reset/det", 32'(m.dbg_det), 32'd0);

    mode = 0; sync_to(60, 100);
    measure("square", 1000, -1, 10, 900);
    next_cycle();
    check("square/done_pulse", 32'(m.done), 32'd0);

    mode = 1; sync_to(10, 0);
    measure("noise", 500, -1, 0, 0);
    next_cycle();
    check("noise/done_pulse", 32'(m.done), 32'd0);

    mode = 2; sync_to(120, 200);
    measure("chatter", 1000, -1, 5, 800);

    mode = 3; sync_to(60, 100);
    measure("gaps", 1000, -1, 10, 900);

    mode = 0; sync_to(60, 100);
    measure("final_edge", 50, -1, 1, 0);

    mode = 0; sync_to(60, 100);
    measure("gate0", 0, -1, 0, 0);

    mode = 0; sync_to(60, 100);
    measure("start_in_run", 300, 150, 3, 200);
    measure("chained", 300, -1, 3, 200);

    // Abort at elapsed=300, then hold in-band so the detector must stay unknown.
    mode = 0; sync_to(60, 148);
    m.start    = 1'b1;
    m.gate_len = GATE_WIDTH'(1000);
    for (int t = 1; t <= 301; t++) begin
      next_cycle();
      m.start = 1'b0;
    end
    rst       = 1'b1;
    mode      = 5;
    const_din = MID;
    m.din     = DATA_WIDTH'(MID);
    next_cycle();
    rst = 1'b0;
    check("abort/busy", 32'(m.busy), 32'd0);
    check("abort/edge_cnt", 32'(m.edge_cnt), 32'd0);
    check("abort/span", 32'(m.span), 32'd0);
    check("abort/span_valid", 32'(m.span_valid), 32'd0);
    check("abort/det", 32'(m.dbg_det), 32'd0);
    any_done = (m.done === 1'b1) ? 1 : 0;
    repeat (5) begin
      next_cycle();
      if (m.done === 1'b1) any_done = 1;
    end
    check("abort/no_done", 32'(any_done), 32'd0);
    mode = 0;
    base = cyc + 1 - 50;
    measure("post_reset", 150, -1, 1, 0);

    for (int r = 0; r < 4; r++) begin
      mode = 4; sync_to(5, 0);
      measure("random", int'($urandom_range(0, 400)), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
